uart_tx_frame: RTL and testbench

//   UART transmitter: serialises one byte per request into start/data/parity/stop frame on TX_OUT.

---
 rtl/uart_tx_frame.sv | 159 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter. Serialises one DATA_WIDTH-bit word per
// accepted request as start / data (LSB first) / optional parity / stop,
// each bit held for Prescale clock cycles (values below 4 run as 4).
// TX_OUT and busy are registered; the outputs are computed from the next
// state so the start bit appears on the same edge that accepts a request.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRE_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRE_WIDTH-1:0]  Prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [PRE_WIDTH-1:0] PRE_MIN  = PRE_WIDTH'(4);
  localparam logic [PRE_WIDTH-1:0] PRE_ONE  = PRE_WIDTH'(1);
  localparam logic [BIT_W-1:0]     BIT_ONE  = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [PRE_WIDTH-1:0]  edge_q, edge_d;
  // Last edge_cnt value of a bit (P-1), captured at acceptance.
  logic [PRE_WIDTH-1:0]  last_q, last_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_done;

  assign bit_done = (edge_q == last_q);
  assign TX_OUT   = tx_q;
  assign busy     = busy_q;

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      edge_q    <= '0;
      last_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      last_q    <= last_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and datapath: request latching, bit timing and sequencing.
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    last_d    = last_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (data_valid) begin
          shift_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = PAR_TYP ? ~^P_DATA : ^P_DATA;
          last_d    = (Prescale < PRE_MIN) ? (PRE_MIN - PRE_ONE)
                                           : (Prescale - PRE_ONE);
          state_d   = START;
        end
      end
      START: begin
        if (bit_done) begin
          edge_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          edge_d = edge_q + PRE_ONE;
        end
      end
      DATA: begin
        if (bit_done) begin
          edge_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          edge_d = edge_q + PRE_ONE;
        end
      end
      PARITY: begin
        if (bit_done) begin
          edge_d  = '0;
          state_d = STOP;
        end else begin
          edge_d = edge_q + PRE_ONE;
        end
      end
      STOP: begin
        if (bit_done) begin
          edge_d  = '0;
          state_d = IDLE;
        end else begin
          edge_d = edge_q + PRE_ONE;
        end
      end
      default: begin
        edge_d  = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the registered line leads by nothing.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      IDLE:    busy_d = 1'b0;
      START:   tx_d   = 1'b0;
      DATA:    tx_d   = shift_d[0];
      PARITY:  tx_d   = par_bit_d;
      STOP:    tx_d   = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: self-checking bench for uart_tx_frame. A behavioural
// model builds each frame as a list of bits and checks TX_OUT / busy on
// every cycle; a vector table adds fixed length and parity expectations.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       busy;

  int vectors;
  int miscompares;

  uart_tx_frame #(
    .DATA_WIDTH(8),
    .PRE_WIDTH (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .TX_OUT    (TX_OUT),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         pt;
    int         pre;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after the accepting edge. Checks the whole frame cycle by
  // cycle, then the idle cycle that must follow it.
  task automatic check_frame(input logic [7:0] d, input bit pe, input bit pt,
                             input int pre, input bit scribble, input string tag,
                             output int busy_cnt, output logic par_seen);
    int bits[$];
    int p;
    int len;
    int ones;
    int extra;
    p = (pre < 4) ? 4 : pre;
    ones = $countones(d);
    bits.push_back(0);
    for (int i = 0; i < 8; i++) bits.push_back(int'(d[i]));
    if (pe) bits.push_back(pt ? int'((ones % 2) == 0) : int'((ones % 2) == 1));
    bits.push_back(1);
    len = bits.size() * p;
    busy_cnt = 0;
    par_seen = 1'bx;
    for (int c = 0; c < len; c++) begin
      chk({tag, " busy"}, busy, 1);
      chk({tag, " tx"}, TX_OUT, bits[c / p]);
      if (busy === 1'b1) busy_cnt++;
      if (pe && c == 9 * p + p / 2) par_seen = TX_OUT;
      if (scribble) begin
        P_DATA     = 8'($urandom);
        Prescale   = 6'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
        data_valid = 1'($urandom);
      end
      step();
    end
    if (scribble) data_valid = 1'b0;
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle tx"}, TX_OUT, 1);
    extra = 0;
    while (busy === 1'b1 && extra < 1000) begin
      busy_cnt++;
      extra++;
      step();
    end
  endtask

  task automatic send(input logic [7:0] d, input bit pe, input bit pt, input int pre,
                      input bit scribble, input string tag,
                      output int busy_cnt, output logic par_seen);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = 6'(pre);
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    check_frame(d, pe, pt, pre, scribble, tag, busy_cnt, par_seen);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   cnt;
    logic ps;
    logic [7:0] rd;
    bit   rpe;
    bit   rpt;
    int   rpre;

    vectors     = 0;
    miscompares = 0;

    tbl[0] = '{8'hA5, 1'b0, 1'b0,  8,  80, 1'b0};
    tbl[1] = '{8'h3C, 1'b1, 1'b0, 16, 176, 1'b0};
    tbl[2] = '{8'h3C, 1'b1, 1'b1, 16, 176, 1'b1};
    tbl[3] = '{8'h01, 1'b1, 1'b0, 16, 176, 1'b1};
    tbl[4] = '{8'hFF, 1'b1, 1'b1,  4,  44, 1'b1};
    tbl[5] = '{8'h00, 1'b1, 1'b1,  2,  44, 1'b1};
    tbl[6] = '{8'h81, 1'b0, 1'b0,  0,  40, 1'b0};
    tbl[7] = '{8'hC3, 1'b1, 1'b0, 63, 693, 1'b0};

    // Reset held 3 cycles with a request pending: reset wins, no frame.
    rst        = 1'b1;
    data_valid = 1'b1;
    P_DATA     = 8'h5A;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd8;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset tx", TX_OUT, 1);
      chk("reset busy", busy, 0);
    end
    rst        = 1'b0;
    data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post-reset tx", TX_OUT, 1);
      chk("post-reset busy", busy, 0);
    end

    // Fixed vectors: model-checked waveform plus tabulated length and parity.
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].data, tbl[i].pe, tbl[i].pt, tbl[i].pre, 1'b0, "table", cnt, ps);
      chk("table busy length", cnt, tbl[i].exp_len);
      if (tbl[i].pe) chk("table parity bit", ps, tbl[i].exp_par);
    end

    // Request held through a frame with inputs changed mid-frame: 0xA5 runs
    // intact, then 0x55 starts after exactly one idle cycle.
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd8;
    data_valid = 1'b1;
    step();
    P_DATA   = 8'h55;
    Prescale = 6'd16;
    PAR_EN   = 1'b1;
    PAR_TYP  = 1'b1;
    check_frame(8'hA5, 1'b0, 1'b0, 8, 1'b0, "b2b first", cnt, ps);
    chk("b2b first length", cnt, 80);
    step();
    data_valid = 1'b0;
    check_frame(8'h55, 1'b1, 1'b1, 16, 1'b0, "b2b second", cnt, ps);
    chk("b2b second length", cnt, 176);
    chk("b2b second parity", ps, 1);

    // Reset during data bit 3 aborts the frame with no resume.
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b0;
    Prescale   = 6'd8;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    for (int i = 0; i < 34; i++) step();
    chk("mid-frame busy", busy, 1);
    chk("mid-frame tx bit3", TX_OUT, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort tx", TX_OUT, 1);
    chk("abort busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort stays idle tx", TX_OUT, 1);
      chk("abort stays idle busy", busy, 0);
    end
    send(8'h3C, 1'b1, 1'b0, 8, 1'b0, "after abort", cnt, ps);
    chk("after abort length", cnt, 88);

    // Randomized frames with inputs scrambled while busy.
    for (int k = 0; k < 40; k++) begin
      rd   = 8'($urandom);
      rpe  = 1'($urandom);
      rpt  = 1'($urandom);
      rpre = $urandom_range(0, 40);
      send(rd, rpe, rpt, rpre, 1'b1, "random", cnt, ps);
      chk("random length", cnt, (10 + int'(rpe)) * ((rpre < 4) ? 4 : rpre));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
